clock_divider_prog: RTL and testbench

- Runtime-programmable successor to the fixed divide-by-constant clock divider.
- Divisor width and reset-default divisor are parameters. Divisor and output mode are reloaded at runtime via a strobe and applied glitch-free at the next terminal count.
- Output modes: square wave (toggle) or one-cycle tick.
- Used as the timebase generator feeding UART baud, PWM and debounce blocks.

---
 rtl/clk_div_pkg.sv | 21 ++
 rtl/clock_divider_prog.sv | 101 ++++++++++
 tb/tb_clock_divider_prog.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and parameter checks for the
// runtime-programmable clock divider.
package clk_div_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } div_mode_e;

  // A reset divisor is legal when nonzero and
  // representable in w bits.
  function automatic bit div_legal(
    input longint unsigned div,
    input int unsigned     w
  );
    if (div == 0) return 1'b0;
    if (w >= 64) return 1'b1;
    return div < (64'd1 << w);
  endfunction

endpackage

// File: rtl/clock_divider_prog.sv
// Programmable clock divider: toggle or tick output,
// divisor/mode reloaded glitch-free at terminal count.
module clock_divider_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned     CNT_W        = 32,
  parameter longint unsigned DEFAULT_DIV  = 50,
  parameter bit              DEFAULT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_mode,
  input  logic             div_load,
  output logic             clk_div,
  output logic             tick,
  output logic             cfg_pending,
  output logic             load_err,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] DEF_DIV =
    CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam div_mode_e DEF_MODE =
    div_mode_e'(DEFAULT_MODE);

  if (!div_legal(DEFAULT_DIV, CNT_W)) begin : g_bad_div
    $error("DEFAULT_DIV must be 1 .. 2^CNT_W-1");
  end

  logic [CNT_W-1:0] active_div;
  logic [CNT_W-1:0] pend_div;
  div_mode_e        active_mode;
  div_mode_e        pend_mode;

  logic             term;
  logic             load_ok;
  logic             load_bad;
  logic             apply_now;
  logic [CNT_W-1:0] last_cnt;

  // Terminal count, load qualification, apply decision
  always_comb begin
    last_cnt  = active_div - ONE;
    term      = enable && (count == last_cnt);
    load_ok   = div_load && (div_val != '0);
    load_bad  = div_load && (div_val == '0);
    apply_now = cfg_pending && (term || !enable);
  end

  // Counter, output edges and config shadow registers
  always_ff @(posedge clk) begin
    if (rst_a) begin
      count       <= '0;
      clk_div     <= 1'b0;
      tick        <= 1'b0;
      load_err    <= 1'b0;
      cfg_pending <= 1'b0;
      active_div  <= DEF_DIV;
      active_mode <= DEF_MODE;
      pend_div    <= '0;
      pend_mode   <= MODE_TOGGLE;
    end else begin
      load_err <= load_bad;
      tick     <= term;

      if (term) begin
        count <= '0;
        if (active_mode == MODE_PULSE)
          clk_div <= 1'b1;
        else
          clk_div <= ~clk_div;
      end else if (enable) begin
        count <= count + ONE;
        if (active_mode == MODE_PULSE)
          clk_div <= 1'b0;
      end else if (cfg_pending) begin
        // Idle apply restarts the period cleanly
        count <= '0;
        if (pend_mode == MODE_PULSE)
          clk_div <= 1'b0;
      end

      if (apply_now) begin
        active_div  <= pend_div;
        active_mode <= pend_mode;
        cfg_pending <= 1'b0;
      end

      // A fresh load wins over a same-edge apply
      if (load_ok) begin
        pend_div    <= div_val;
        pend_mode   <= div_mode_e'(div_mode);
        cfg_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog:
// directed scenarios plus randomized traffic vs a model.
module tb_clock_divider_prog;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_a = 1'b1;
  logic         enable = 1'b0;
  logic [W-1:0] div_val = '0;
  logic         div_mode = 1'b0;
  logic         div_load = 1'b0;
  logic         clk_div;
  logic         tick;
  logic         cfg_pending;
  logic         load_err;
  logic [W-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  longint m_count, m_adiv, m_pdiv;
  bit     m_clk, m_tick, m_pend, m_err;
  bit     m_amode, m_pmode;

  clock_divider_prog #(
    .CNT_W(W),
    .DEFAULT_DIV(50),
    .DEFAULT_MODE(1'b0)
  ) dut (
    .clk(clk),
    .rst_a(rst_a),
    .enable(enable),
    .div_val(div_val),
    .div_mode(div_mode),
    .div_load(div_load),
    .clk_div(clk_div),
    .tick(tick),
    .cfg_pending(cfg_pending),
    .load_err(load_err),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // One edge of the spec behaviour, in plain arithmetic.
  task automatic model_step(
    input bit     r,
    input bit     en,
    input bit     ld,
    input longint dv,
    input bit     dm
  );
    bit t;
    bit apply;
    if (r) begin
      m_count = 0; m_clk = 0; m_tick = 0;
      m_pend = 0; m_err = 0;
      m_adiv = 50; m_amode = 0;
      m_pdiv = 0; m_pmode = 0;
      return;
    end
    t     = en && (m_count == m_adiv - 1);
    apply = m_pend && (t || !en);
    m_err  = ld && (dv == 0);
    m_tick = t;
    if (t) begin
      m_count = 0;
      m_clk   = m_amode ? 1'b1 : !m_clk;
    end else if (en) begin
      m_count = m_count + 1;
      if (m_amode) m_clk = 0;
    end
    if (apply) begin
      m_adiv  = m_pdiv;
      m_amode = m_pmode;
      m_pend  = 0;
      if (!en) begin
        m_count = 0;
        if (m_amode) m_clk = 0;
      end
    end
    if (ld && dv != 0) begin
      m_pdiv = dv; m_pmode = dm; m_pend = 1;
    end
  endtask

  task automatic cyc(
    input bit           r,
    input bit           en,
    input bit           ld,
    input logic [W-1:0] dv,
    input bit           dm
  );
    rst_a = r; enable = en; div_load = ld;
    div_val = dv; div_mode = dm;
    @(posedge clk);
    model_step(r, en, ld, longint'(dv), dm);
    #1;
    chk("count", 64'(count), 64'(m_count));
    chk("clk_div", 64'(clk_div), 64'(m_clk));
    chk("tick", 64'(tick), 64'(m_tick));
    chk("cfg_pending", 64'(cfg_pending), 64'(m_pend));
    chk("load_err", 64'(load_err), 64'(m_err));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, '0, 0);
  endtask

  // cycles until tick is seen, bounded by lim
  task automatic wait_tick(output int n, input int lim);
    n = 0;
    do begin
      cyc(0, 1, 0, '0, 0);
      n++;
    end while (tick !== 1'b1 && n < lim);
  endtask

  task automatic run_to_count(input longint v);
    int k;
    k = 0;
    while (m_count != v && k < 400) begin
      cyc(0, 1, 0, '0, 0);
      k++;
    end
    chk("reach_count", 64'(count), 64'(v));
  endtask

  initial begin
    int n;
    int n_tick;
    int n_high;
    bit held;
    bit r, en, ld, dm;
    logic [W-1:0] dv;
    int k;

    // reset and defaults
    cyc(1, 0, 0, '0, 0);
    cyc(1, 1, 0, '0, 0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_clk_div", 64'(clk_div), 64'd0);
    chk("rst_pending", 64'(cfg_pending), 64'd0);

    // default divide-by-50 toggle over 400 cycles
    n_tick = 0;
    n_high = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(0, 1, 0, '0, 0);
      n_tick += int'(tick);
      n_high += int'(clk_div);
    end
    chk("def_ticks", 64'(n_tick), 64'd8);
    chk("def_high", 64'(n_high), 64'd200);
    chk("def_wrap", 64'(count), 64'd0);

    // mid-period reload to 4 at count 10
    run_to_count(10);
    cyc(0, 1, 1, 32'd4, 0);
    chk("ld4_pending", 64'(cfg_pending), 64'd1);
    wait_tick(n, 100);
    chk("ld4_old_gap", 64'(n), 64'd39);
    chk("ld4_applied", 64'(cfg_pending), 64'd0);
    wait_tick(n, 100);
    chk("ld4_new_gap", 64'(n), 64'd4);
    run(16);

    // zero divisor rejected, pending kept
    cyc(0, 1, 1, 32'd7, 0);
    cyc(0, 1, 1, 32'd0, 1);
    chk("ld0_err", 64'(load_err), 64'd1);
    chk("ld0_pending", 64'(cfg_pending), 64'd1);
    cyc(0, 1, 0, '0, 0);
    chk("ld0_err_clr", 64'(load_err), 64'd0);

    // divide-by-1 pulse: tick and clk_div stuck high
    cyc(0, 1, 1, 32'd1, 1);
    wait_tick(n, 100);
    run(2);
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0, '0, 0);
      held &= tick & clk_div;
    end
    chk("div1_pulse_high", 64'(held), 64'd1);

    // hold with enable=0 at count 7, load while held
    cyc(0, 1, 1, 32'd20, 0);
    run(2);
    run_to_count(7);
    held = 1'b1;
    n = int'(clk_div);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, '0, 0);
      held &= (count == 7) && !tick &&
              (int'(clk_div) == n);
    end
    chk("hold_stable", 64'(held), 64'd1);
    cyc(0, 0, 1, 32'd12, 0);
    chk("hold_ld_pending", 64'(cfg_pending), 64'd1);
    cyc(0, 0, 0, '0, 0);
    chk("hold_apply_cnt", 64'(count), 64'd0);
    chk("hold_apply_pend", 64'(cfg_pending), 64'd0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, '0, 0);
    wait_tick(n, 100);
    chk("hold_first_gap", 64'(n), 64'd12);

    // two loads before T: last wins
    cyc(0, 1, 1, 32'd6, 0);
    cyc(0, 1, 1, 32'd9, 0);
    wait_tick(n, 100);
    chk("two_ld_old_gap", 64'(n), 64'd10);
    wait_tick(n, 100);
    chk("two_ld_new_gap", 64'(n), 64'd9);

    // load coincident with T waits one period
    run_to_count(8);
    cyc(0, 1, 1, 32'd5, 0);
    chk("coinc_tick", 64'(tick), 64'd1);
    chk("coinc_pending", 64'(cfg_pending), 64'd1);
    wait_tick(n, 100);
    chk("coinc_old_gap", 64'(n), 64'd9);
    wait_tick(n, 100);
    chk("coinc_new_gap", 64'(n), 64'd5);

    // wide divisor: full-width compare
    cyc(0, 1, 1, 32'd260, 0);
    wait_tick(n, 100);
    wait_tick(n, 400);
    chk("wide_gap", 64'(n), 64'd260);

    // reset mid-period with a pending load
    run(3);
    cyc(0, 1, 1, 32'd30, 1);
    cyc(1, 1, 0, '0, 0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_clk", 64'(clk_div), 64'd0);
    chk("mid_rst_pend", 64'(cfg_pending), 64'd0);
    wait_tick(n, 100);
    chk("mid_rst_gap", 64'(n), 64'd50);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 99) < 85);
      ld = ($urandom_range(0, 7) == 0);
      dm = 1'($urandom_range(0, 1));
      k  = int'($urandom_range(0, 19));
      if (k == 0)
        dv = '0;
      else if (k == 1)
        dv = W'($urandom_range(60, 120));
      else
        dv = W'($urandom_range(1, 12));
      cyc(r, en, ld, dv, dm);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
